// File: rtl/jtdsp16_sio_rx_pkg.sv
// Shared SIO word/address geometry and default channel addresses for the
// DSP16 serial-output receiver.
package jtdsp16_sio_rx_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 5;

   localparam logic [ADDR_W-1:0] DEF_ADDR_L = 8'h00;
   localparam logic [ADDR_W-1:0] DEF_ADDR_R = 8'h01;

   typedef enum logic {
      CH_L = 1'b0,
      CH_R = 1'b1
   } chan_e;

endpackage

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 SIO output deserialiser: rebuilds 16-bit words from ock/sio_do/old/sadd
// and routes them into left/right sample registers.
module jtdsp16_sio_rx
   import jtdsp16_sio_rx_pkg::*;
#(
   parameter logic [7:0] ADDR_L  = DEF_ADDR_L,
   parameter logic [7:0] ADDR_R  = DEF_ADDR_R,
   parameter bit         ADDR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        ock,
   input  logic        sio_do,
   input  logic        old,
   input  logic        sadd,
   output logic [15:0] left,
   output logic [15:0] right,
   output logic        sample_stb,
   output logic        frame_err,
   output logic        addr_miss,
   output logic [7:0]  debug_addr
);

   logic              last_ock;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] dsr;
   logic [ADDR_W-1:0] asr;
   logic              done;
   chan_e             toggle;

   logic strobe, abort, complete;
   logic to_left, to_right, miss;

   always_comb begin
      strobe   = ock & ~last_ock & ~old;
      abort    = old & (cnt != '0);
      complete = strobe & (cnt == 5'd15);
      to_left  = 1'b0;
      to_right = 1'b0;
      miss     = 1'b0;
      if (ADDR_EN) begin
         // Equal L/R addresses resolve to the left channel.
         to_left  = (asr == ADDR_L);
         to_right = !to_left && (asr == ADDR_R);
         miss     = !to_left && !to_right;
      end else begin
         to_left  = (toggle == CH_L);
         to_right = (toggle == CH_R);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ock   <= 1'b0;
         cnt        <= '0;
         dsr        <= '0;
         asr        <= '0;
         done       <= 1'b0;
         toggle     <= CH_L;
         left       <= '0;
         right      <= '0;
         sample_stb <= 1'b0;
         frame_err  <= 1'b0;
         addr_miss  <= 1'b0;
         debug_addr <= '0;
      end else if (cen) begin
         last_ock   <= ock;
         sample_stb <= 1'b0;
         frame_err  <= 1'b0;
         addr_miss  <= 1'b0;
         done       <= complete;
         if (strobe) begin
            dsr <= {dsr[WORD_W-2:0], sio_do};
            if (cnt < 5'd8) asr <= {asr[ADDR_W-2:0], sadd};
            cnt <= complete ? '0 : cnt + 5'd1;
         end else if (abort) begin
            cnt       <= '0;
            frame_err <= 1'b1;
         end
         // Routing runs one cycle after the 16th bit, so a following word may
         // already be shifting in; dsr/asr still hold the finished word here.
         if (done) begin
            debug_addr <= asr;
            addr_miss  <= miss;
            if (to_left) left <= dsr;
            if (to_right) begin
               right      <= dsr;
               sample_stb <= 1'b1;
            end
            if (!ADDR_EN) toggle <= (toggle == CH_L) ? CH_R : CH_L;
         end
      end
   end

endmodule
